cnn_sdiv_24s_9s_seq: RTL and testbench

Iterative signed divider, the inverse of the conv1 fixed-point 14s x 9s -> 24s product multiply. It recovers a 14-bit signed value from a 24-bit signed product/accumulator and a 9-bit signed weight/scale. Typical uses are requantization and dequantization of conv1 outputs. Valid/ready on both sides; one bit of quotient per clock (restoring division on magnitudes), then sign fix and saturation.

---
 rtl/cnn_sdiv_24s_9s_seq_if.sv | 28 ++
 rtl/cnn_sdiv_24s_9s_seq.sv | 149 ++++++++++++++
 tb/tb_cnn_sdiv_24s_9s_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cnn_sdiv_24s_9s_seq_if.sv
// Operand/result handshake bundle for the iterative signed divider.
// slave: divider side; master: operand source and result sink.
interface cnn_sdiv_24s_9s_seq_if #(
    parameter int DIVIDEND_W = 24,
    parameter int DIVISOR_W  = 9,
    parameter int QUOT_W     = 14
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [QUOT_W-1:0]     quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  overflow;
    logic                  div_by_zero;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/cnn_sdiv_24s_9s_seq.sv
// Restoring signed divider, 24s / 9s -> saturated 14s quotient + 9s remainder, one quotient bit per clock.
// Result valid DIVIDEND_W+2 edges after accept (2 for divide-by-zero); result held until out_ready, no accept while busy.
module cnn_sdiv_24s_9s_seq #(
    parameter int DIVIDEND_W = 24,
    parameter int DIVISOR_W  = 9,
    parameter int QUOT_W     = 14
) (
    input logic                  ap_clk,
    input logic                  ap_rst_n,
    cnn_sdiv_24s_9s_seq_if.slave bus
);
    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam int PR_W  = DIVISOR_W + 1;
    localparam int QS_W  = DIVIDEND_W + 1;

    localparam logic signed [QS_W-1:0] Q_MAX  = QS_W'(2 ** (QUOT_W - 1) - 1);
    localparam logic signed [QS_W-1:0] Q_MIN  = QS_W'(-(2 ** (QUOT_W - 1)));
    localparam logic [QUOT_W-1:0]      QO_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0]      QO_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, CALC, FIX, SAT, DONE} state_t;

    state_t                   state;
    logic [CNT_W-1:0]         count;
    logic [DIVIDEND_W-1:0]    acc;
    logic [DIVISOR_W-1:0]     dmag;
    logic [DIVISOR_W-1:0]     rem_q;
    logic                     dvd_neg;
    logic                     q_neg;
    logic                     dz;
    logic signed [QS_W-1:0]   q_fix;
    logic signed [DIVISOR_W-1:0] r_fix;

    logic                     in_rdy;
    logic                     res_vld;
    logic [QUOT_W-1:0]        q_out;
    logic [DIVISOR_W-1:0]     r_out;
    logic                     ovf;
    logic                     dz_out;

    // acc shifts dividend magnitude bits out of its MSB and quotient bits in at its LSB
    logic [PR_W-1:0]          prem;
    logic [DIVISOR_W-1:0]     diff;
    logic                     qbit;
    logic signed [QS_W-1:0]   q_mag;
    logic signed [DIVISOR_W-1:0] r_mag;

    assign prem  = {rem_q, acc[DIVIDEND_W-1]};
    assign qbit  = (prem >= {1'b0, dmag});
    assign diff  = DIVISOR_W'(prem - {1'b0, dmag});
    assign q_mag = $signed({1'b0, acc});
    assign r_mag = $signed(rem_q);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state   <= IDLE;
            count   <= '0;
            acc     <= '0;
            dmag    <= '0;
            rem_q   <= '0;
            dvd_neg <= 1'b0;
            q_neg   <= 1'b0;
            dz      <= 1'b0;
            q_fix   <= '0;
            r_fix   <= '0;
            in_rdy  <= 1'b0;
            res_vld <= 1'b0;
            q_out   <= '0;
            r_out   <= '0;
            ovf     <= 1'b0;
            dz_out  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_rdy <= 1'b1;
                    if (in_rdy && bus.in_valid) begin
                        in_rdy  <= 1'b0;
                        // two's-complement magnitude is exact for the most negative value as unsigned
                        acc     <= bus.dividend[DIVIDEND_W-1] ? (~bus.dividend + 1'b1) : bus.dividend;
                        dmag    <= bus.divisor[DIVISOR_W-1] ? (~bus.divisor + 1'b1) : bus.divisor;
                        rem_q   <= '0;
                        count   <= '0;
                        dvd_neg <= bus.dividend[DIVIDEND_W-1];
                        q_neg   <= bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
                        dz      <= (bus.divisor == '0);
                        state   <= (bus.divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    acc   <= {acc[DIVIDEND_W-2:0], qbit};
                    rem_q <= qbit ? diff : prem[DIVISOR_W-1:0];
                    count <= count + 1'b1;
                    if (count == CNT_W'(DIVIDEND_W - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    q_fix <= q_neg ? -q_mag : q_mag;
                    r_fix <= dvd_neg ? -r_mag : r_mag;
                    state <= SAT;
                end
                SAT: begin
                    res_vld <= 1'b1;
                    state   <= DONE;
                    if (dz) begin
                        q_out  <= dvd_neg ? QO_MIN : QO_MAX;
                        r_out  <= '0;
                        ovf    <= 1'b0;
                        dz_out <= 1'b1;
                    end else if (q_fix > Q_MAX) begin
                        q_out  <= QO_MAX;
                        r_out  <= r_fix;
                        ovf    <= 1'b1;
                        dz_out <= 1'b0;
                    end else if (q_fix < Q_MIN) begin
                        q_out  <= QO_MIN;
                        r_out  <= r_fix;
                        ovf    <= 1'b1;
                        dz_out <= 1'b0;
                    end else begin
                        q_out  <= q_fix[QUOT_W-1:0];
                        r_out  <= r_fix;
                        ovf    <= 1'b0;
                        dz_out <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        res_vld <= 1'b0;
                        ovf     <= 1'b0;
                        dz_out  <= 1'b0;
                        in_rdy  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = res_vld;
    assign bus.quotient    = q_out;
    assign bus.remainder   = r_out;
    assign bus.overflow    = ovf;
    assign bus.div_by_zero = dz_out;
endmodule

// File: tb/tb_cnn_sdiv_24s_9s_seq.sv
// Directed + random checks of the iterative signed divider against an integer-arithmetic model.
module tb_cnn_sdiv_24s_9s_seq;
    logic ap_clk;
    logic ap_rst_n;

    cnn_sdiv_24s_9s_seq_if bus ();

    cnn_sdiv_24s_9s_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [13:0] q;
        logic [8:0]  r;
        logic        ovf;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t   e;
        longint q;
        e.lat = 26;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (b == 0) begin
            e.q   = (a >= 0) ? 14'd8191 : 14'h2000;
            e.r   = '0;
            e.dz  = 1'b1;
            e.lat = 2;
        end else begin
            q   = longint'(a) / longint'(b);
            e.r = 9'(a % b);
            if (q > 8191) begin
                q     = 8191;
                e.ovf = 1'b1;
            end else if (q < -8192) begin
                q     = -8192;
                e.ovf = 1'b1;
            end
            e.q = 14'(q);
        end
        return e;
    endfunction

    // Drive one operation, score its result, optionally hold out_ready low for 'hold' cycles.
    task automatic run_op(input string tag, input int a, input int b, input int hold);
        exp_t e;
        int   lat;
        int   waited;
        waited = 0;
        @(negedge ap_clk);
        while (!bus.in_ready && waited < 100) begin
            @(negedge ap_clk);
            waited++;
        end
        check({tag, ":in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.dividend = 24'(a);
        bus.divisor  = 9'(b);
        bus.in_valid = 1'b1;
        sb.push_back(model(a, b));
        @(negedge ap_clk);
        bus.in_valid = 1'b0;
        bus.dividend = ~bus.dividend;
        bus.divisor  = ~bus.divisor;
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            @(negedge ap_clk);
            lat++;
        end
        if (sb.size() == 0) begin
            check({tag, ":scoreboard_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, ":latency"}, 32'(lat), 32'(e.lat));
        check({tag, ":quotient"}, 32'(bus.quotient), 32'(e.q));
        check({tag, ":remainder"}, 32'(bus.remainder), 32'(e.r));
        check({tag, ":overflow"}, 32'(bus.overflow), 32'(e.ovf));
        check({tag, ":div_by_zero"}, 32'(bus.div_by_zero), 32'(e.dz));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = i[0];
            bus.dividend = 24'(i * 37);
            bus.divisor  = 9'(i + 1);
            @(negedge ap_clk);
            check({tag, ":hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ":hold_quotient"}, 32'(bus.quotient), 32'(e.q));
            check({tag, ":hold_remainder"}, 32'(bus.remainder), 32'(e.r));
            check({tag, ":hold_flags"}, 32'({bus.overflow, bus.div_by_zero}), 32'({e.ovf, e.dz}));
            check({tag, ":hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge ap_clk);
        bus.out_ready = 1'b0;
        check({tag, ":after_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ":after_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, ":after_flags"}, 32'({bus.overflow, bus.div_by_zero}), 32'd0);
    endtask

    initial begin
        logic [23:0] ra;
        logic [8:0]  rb;
        int          quiet;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        ap_rst_n      = 1'b0;
        repeat (3) @(negedge ap_clk);
        check("rst:in_ready", 32'(bus.in_ready), 32'd0);
        check("rst:out_valid", 32'(bus.out_valid), 32'd0);
        check("rst:quotient", 32'(bus.quotient), 32'd0);
        check("rst:remainder", 32'(bus.remainder), 32'd0);
        check("rst:flags", 32'({bus.overflow, bus.div_by_zero}), 32'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("rst:in_ready_release", 32'(bus.in_ready), 32'd1);

        run_op("pos_pos", 1000, 7, 0);
        run_op("neg_pos", -1000, 7, 0);
        run_op("pos_neg", 1000, -7, 0);
        run_op("neg_neg", -1000, -7, 0);
        run_op("exact_min", 2097152, -256, 0);
        run_op("sat_max", 8388607, 1, 0);
        run_op("sat_min", -8388608, 1, 0);
        run_op("sat_minmin", -8388608, -256, 0);
        run_op("edge_8191", 2088705, 255, 0);
        run_op("dz_pos", 123, 0, 0);
        run_op("dz_neg", -5, 0, 0);
        run_op("after_dz", 10, 3, 0);
        run_op("backpressure", 1000, 7, 10);
        run_op("back_to_back", 50, -6, 0);

        // Reset on the 10th CALC cycle must discard the operation.
        @(negedge ap_clk);
        bus.dividend = 24'(1000);
        bus.divisor  = 9'(7);
        bus.in_valid = 1'b1;
        @(negedge ap_clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        check("midrst:out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst:in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst:quotient", 32'(bus.quotient), 32'd0);
        check("midrst:remainder", 32'(bus.remainder), 32'd0);
        check("midrst:flags", 32'({bus.overflow, bus.div_by_zero}), 32'd0);
        @(negedge ap_clk);
        check("midrst:in_ready_release", 32'(bus.in_ready), 32'd1);
        quiet = 0;
        repeat (30) begin
            @(negedge ap_clk);
            if (bus.out_valid) quiet++;
        end
        check("midrst:no_stale_result", 32'(quiet), 32'd0);
        run_op("after_rst", 77, 11, 0);

        for (int i = 0; i < 20; i++) begin
            ra = 24'($urandom);
            rb = 9'($urandom);
            if (i % 3 == 0) ra = 24'($signed(ra) >>> 8);
            run_op("random", int'($signed(ra)), int'($signed(rb)), i % 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
